// File: rtl/transformation_scheduler.sv
// Sequences the feature-by-weight transformation pass: per weight column, load the column into
// the scratch pad, then stream every feature row and write one product element per (row, col).
module transformation_scheduler #(
    parameter int unsigned WEIGHT_COLS  = 3,
    parameter int unsigned FEATURE_ROWS = 6,
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned WEIGHT_BASE  = 0,
    parameter int unsigned FEATURE_BASE = 512,
    parameter int unsigned COL_W        = 2,
    parameter int unsigned ROW_W        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mem_gnt,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  scratch_we,
    output logic                  prod_we,
    output logic [ROW_W-1:0]      prod_row,
    output logic [COL_W-1:0]      prod_col,
    output logic                  busy,
    output logic                  done
);

    localparam logic [COL_W-1:0]      LastCol = COL_W'(WEIGHT_COLS - 1);
    localparam logic [ROW_W-1:0]      LastRow = ROW_W'(FEATURE_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] WBase   = ADDR_WIDTH'(WEIGHT_BASE);
    localparam logic [ADDR_WIDTH-1:0] FBase   = ADDR_WIDTH'(FEATURE_BASE);

    typedef enum logic [2:0] {
        StIdle,
        StReqW,
        StWaitW,
        StReqF,
        StWaitF,
        StDone
    } state_e;

    state_e           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= StReqW;
                    end
                end
                StReqW:  if (mem_gnt) state_q <= StWaitW;
                StWaitW: state_q <= StReqF;
                StReqF:  if (mem_gnt) state_q <= StWaitF;
                StWaitF: begin
                    // Rows are the inner loop; a new column reloads the scratch pad first.
                    if (row_q < LastRow) begin
                        row_q   <= row_q + ROW_W'(1);
                        state_q <= StReqF;
                    end else if (col_q < LastCol) begin
                        row_q   <= '0;
                        col_q   <= col_q + COL_W'(1);
                        state_q <= StReqW;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = '0;
        scratch_we = 1'b0;
        prod_we    = 1'b0;
        prod_row   = '0;
        prod_col   = '0;
        busy       = (state_q != StIdle);
        done       = 1'b0;
        case (state_q)
            StReqW: begin
                mem_req  = 1'b1;
                mem_addr = WBase + ADDR_WIDTH'(col_q);
            end
            StWaitW: scratch_we = 1'b1;
            StReqF: begin
                mem_req  = 1'b1;
                mem_addr = FBase + ADDR_WIDTH'(row_q);
            end
            StWaitF: begin
                prod_we  = 1'b1;
                prod_row = row_q;
                prod_col = col_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_transformation_scheduler.sv
// Self-checking bench: directed vector table, timing scenarios and random traffic against a
// step-list reference model of the transformation pass.
module tb_transformation_scheduler;

    localparam int WCOLS = 3;
    localparam int FROWS = 6;
    localparam int AW    = 13;
    localparam int WBASE = 0;
    localparam int FBASE = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mem_gnt = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          scratch_we;
    logic          prod_we;
    logic [2:0]    prod_row;
    logic [1:0]    prod_col;
    logic          busy;
    logic          done;

    transformation_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_gnt    (mem_gnt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .scratch_we (scratch_we),
        .prod_we    (prod_we),
        .prod_row   (prod_row),
        .prod_col   (prod_col),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a pass is a flat list of steps; request steps wait for a grant.
    // kind: 1 weight request, 2 scratch load, 3 feature request, 4 product write, 5 done
    typedef struct {
        int kind;
        int addr;
        int row;
        int col;
    } step_t;

    step_t plan[$];
    int    ptr = 0;
    bit    active = 1'b0;

    function automatic void build_plan();
        plan.delete();
        for (int c = 0; c < WCOLS; c++) begin
            plan.push_back('{1, (WBASE + c) % (1 << AW), 0, 0});
            plan.push_back('{2, 0, 0, 0});
            for (int r = 0; r < FROWS; r++) begin
                plan.push_back('{3, (FBASE + r) % (1 << AW), 0, 0});
                plan.push_back('{4, 0, r, c});
            end
        end
        plan.push_back('{5, 0, 0, 0});
    endfunction

    function automatic void model_update(input logic s, input logic g, input logic r);
        if (r) begin
            active = 1'b0;
        end else if (!active) begin
            if (s) begin
                build_plan();
                ptr    = 0;
                active = 1'b1;
            end
        end else begin
            if (!((plan[ptr].kind == 1 || plan[ptr].kind == 3) && !g)) ptr++;
            if (ptr >= plan.size()) active = 1'b0;
        end
    endfunction

    function automatic void check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    // Scenario bookkeeping
    int cyc = 0;
    int done_q[$];
    int addr_q[$];
    int pw_cnt, sw_cnt, busy_cnt, low_busy;

    task automatic clear_stats();
        cyc = 0;
        done_q.delete();
        addr_q.delete();
        pw_cnt = 0;
        sw_cnt = 0;
        busy_cnt = 0;
        low_busy = 0;
    endtask

    task automatic tick(input logic s, input logic g, input logic r);
        int k;
        logic e_req, e_sw, e_pw, e_busy, e_done, chk_addr;
        int e_addr, e_row, e_col;
        bit bad;
        start = s;
        mem_gnt = g;
        reset = r;
        @(negedge clk);
        k = active ? plan[ptr].kind : 0;
        e_req  = (k == 1 || k == 3);
        e_addr = e_req ? plan[ptr].addr : 0;
        e_sw   = (k == 2);
        e_pw   = (k == 4);
        e_row  = e_pw ? plan[ptr].row : 0;
        e_col  = e_pw ? plan[ptr].col : 0;
        e_busy = active;
        e_done = (k == 5);
        chk_addr = e_req || !active;
        vectors++;
        bad = (mem_req !== e_req) || (scratch_we !== e_sw) || (prod_we !== e_pw) ||
              (int'(prod_row) != e_row) || (int'(prod_col) != e_col) || $isunknown(prod_row) ||
              $isunknown(prod_col) || (busy !== e_busy) || (done !== e_done) ||
              (chk_addr && (int'(mem_addr) != e_addr || $isunknown(mem_addr)));
        if (bad) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got req=%b addr=%0d sw=%b pw=%b row=%0d col=%0d busy=%b done=%b, expected req=%b addr=%0d sw=%b pw=%b row=%0d col=%0d busy=%b done=%b",
                     cyc, mem_req, mem_addr, scratch_we, prod_we, prod_row, prod_col, busy, done,
                     e_req, e_addr, e_sw, e_pw, e_row, e_col, e_busy, e_done);
        end
        if (done) done_q.push_back(cyc);
        if (mem_req && g) addr_q.push_back(int'(mem_addr));
        if (prod_we) pw_cnt++;
        if (scratch_we) sw_cnt++;
        if (busy) busy_cnt++;
        if (!busy && cyc >= 1 && cyc <= 87) low_busy++;
        @(posedge clk);
        model_update(s, g, r);
        #1;
        cyc++;
    endtask

    task automatic check_full_pass(input string tag);
        int exp_addr[$];
        for (int c = 0; c < WCOLS; c++) begin
            exp_addr.push_back(WBASE + c);
            for (int r = 0; r < FROWS; r++) exp_addr.push_back(FBASE + r);
        end
        check({tag, " done count"}, done_q.size(), 1);
        if (done_q.size() > 0) check({tag, " done cycle"}, done_q[0], 43);
        check({tag, " prod_we count"}, pw_cnt, 18);
        check({tag, " scratch_we count"}, sw_cnt, 3);
        check({tag, " busy cycles"}, busy_cnt, 43);
        check({tag, " accepted reads"}, addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
            check({tag, " read address"}, addr_q[i], exp_addr[i]);
    endtask

    typedef struct {
        logic s, g, r;
        logic req;
        int   addr;
        logic sw, pw;
        int   row, col;
        logic bsy, dn;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0,   1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0,   1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 512, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 512, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 513, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b1, 1, 0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 514, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 0,   1'b0, 1'b0, 0, 0, 1'b1, 1'b0};

        // Power-up reset for two cycles
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_update(1'b0, 1'b1, 1'b1);

        // Idle after reset
        clear_stats();
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        check("idle busy cycles", busy_cnt, 0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            bit bad;
            start = tbl[i].s;
            mem_gnt = tbl[i].g;
            reset = tbl[i].r;
            @(negedge clk);
            vectors++;
            bad = (mem_req !== tbl[i].req) || (scratch_we !== tbl[i].sw) ||
                  (prod_we !== tbl[i].pw) || (int'(prod_row) != tbl[i].row) ||
                  (int'(prod_col) != tbl[i].col) || (busy !== tbl[i].bsy) ||
                  (done !== tbl[i].dn) ||
                  ((tbl[i].req || !tbl[i].bsy) && int'(mem_addr) != tbl[i].addr);
            if (bad) begin
                miscompares++;
                $display("FAIL table[%0d]: got req=%b addr=%0d sw=%b pw=%b row=%0d col=%0d busy=%b done=%b, expected req=%b addr=%0d sw=%b pw=%b row=%0d col=%0d busy=%b done=%b",
                         i, mem_req, mem_addr, scratch_we, prod_we, prod_row, prod_col, busy,
                         done, tbl[i].req, tbl[i].addr, tbl[i].sw, tbl[i].pw, tbl[i].row,
                         tbl[i].col, tbl[i].bsy, tbl[i].dn);
            end
            @(posedge clk);
            model_update(tbl[i].s, tbl[i].g, tbl[i].r);
            #1;
        end
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);

        // Full pass with grant tied high
        clear_stats();
        tick(1'b1, 1'b1, 1'b0);
        repeat (50) tick(1'b0, 1'b1, 1'b0);
        check_full_pass("full pass");

        // Grant stall during the row-2 feature request of column 1 (cycles 21-25)
        clear_stats();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 55; i++) tick(1'b0, !(i >= 21 && i <= 25), 1'b0);
        check("stall done count", done_q.size(), 1);
        if (done_q.size() > 0) check("stall done cycle", done_q[0], 48);
        check("stall prod_we count", pw_cnt, 18);

        // start while busy and during done is ignored
        clear_stats();
        for (int i = 0; i <= 50; i++) tick(i == 0 || i == 10 || i == 43, 1'b1, 1'b0);
        check_full_pass("start while busy");

        // Back-to-back passes with start held high
        clear_stats();
        for (int i = 0; i <= 88; i++) tick(1'b1, 1'b1, 1'b0);
        check("b2b done count", done_q.size(), 2);
        if (done_q.size() > 0) check("b2b first done", done_q[0], 43);
        if (done_q.size() > 1) check("b2b second done", done_q[1], 87);
        check("b2b idle cycles", low_busy, 1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);

        // Reset during the row-3 product write of column 2
        clear_stats();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 37; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        check("abort done count", done_q.size(), 0);
        check("abort prod_we count", pw_cnt, 16);
        check("abort busy cycles", busy_cnt, 38);
        clear_stats();
        tick(1'b1, 1'b1, 1'b0);
        repeat (50) tick(1'b0, 1'b1, 1'b0);
        check_full_pass("after abort");

        // Random traffic
        clear_stats();
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
